// File: rtl/ex_stage.sv
// Execute stage for the rv64IM core: single-cycle ALU/multiplier, iterative restoring divider, registered EX/MEM output.
// Optional macro DIV_RADIX4_EN switches the divider to 2 quotient bits per cycle.
module ex_stage #(
  parameter int XLEN               = 64,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic [4:0]      aluop_i,
  input  logic            rf_wen_i,
  input  logic [4:0]      rd_i,
  input  logic            load_i,
  input  logic            store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] sdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            rf_wen_o,
  output logic [4:0]      rd_o,
  output logic            load_o,
  output logic            store_o,
  output logic [2:0]      funct3_o,
  output logic [XLEN-1:0] sdata_o
);

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_ADDW   = 5'd10;
  localparam logic [4:0] ALU_SUBW   = 5'd11;
  localparam logic [4:0] ALU_SLLW   = 5'd12;
  localparam logic [4:0] ALU_SRLW   = 5'd13;
  localparam logic [4:0] ALU_SRAW   = 5'd14;
  localparam logic [4:0] ALU_MUL    = 5'd15;
  localparam logic [4:0] ALU_MULH   = 5'd16;
  localparam logic [4:0] ALU_MULHSU = 5'd17;
  localparam logic [4:0] ALU_MULHU  = 5'd18;
  localparam logic [4:0] ALU_MULW   = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam logic [4:0] ALU_DIVW   = 5'd24;
  localparam logic [4:0] ALU_DIVUW  = 5'd25;
  localparam logic [4:0] ALU_REMW   = 5'd26;
  localparam logic [4:0] ALU_REMUW  = 5'd27;

`ifdef DIV_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = DIV_BITS_PER_CYCLE;
`endif
  localparam int ITER = XLEN / STEP;

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t          state;
  logic [6:0]      cnt;
  logic [XLEN-1:0] quo_q, rem_q, div_b_q;
  logic            q_neg_q, r_neg_q, rem_sel_q, w_q;
  logic            rf_wen_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;

  logic [XLEN-1:0]   alu_res;
  logic [31:0]       w_res;
  logic              use_w;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_hi, corr1, corr2;
  logic [5:0]        sh6;
  logic [4:0]        sh5;

  assign ready_o = (state == IDLE);
  assign sh6     = operand2_i[5:0];
  assign sh5     = operand2_i[4:0];
  // One unsigned 64x64 product; signed high halves are corrected by subtracting the other operand.
  assign prod    = {{XLEN{1'b0}}, operand1_i} * {{XLEN{1'b0}}, operand2_i};
  assign mul_hi  = prod[2*XLEN-1:XLEN];
  assign corr1   = operand1_i[XLEN-1] ? operand2_i : '0;
  assign corr2   = operand2_i[XLEN-1] ? operand1_i : '0;

  always_comb begin
    alu_res = '0;
    w_res   = '0;
    use_w   = 1'b0;
    case (aluop_i)
      ALU_ADD:    alu_res = operand1_i + operand2_i;
      ALU_SUB:    alu_res = operand1_i - operand2_i;
      ALU_SLL:    alu_res = operand1_i << sh6;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(operand1_i) < $signed(operand2_i))};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (operand1_i < operand2_i)};
      ALU_XOR:    alu_res = operand1_i ^ operand2_i;
      ALU_SRL:    alu_res = operand1_i >> sh6;
      ALU_SRA:    alu_res = $signed(operand1_i) >>> sh6;
      ALU_OR:     alu_res = operand1_i | operand2_i;
      ALU_AND:    alu_res = operand1_i & operand2_i;
      ALU_ADDW:   begin use_w = 1'b1; w_res = operand1_i[31:0] + operand2_i[31:0]; end
      ALU_SUBW:   begin use_w = 1'b1; w_res = operand1_i[31:0] - operand2_i[31:0]; end
      ALU_SLLW:   begin use_w = 1'b1; w_res = operand1_i[31:0] << sh5; end
      ALU_SRLW:   begin use_w = 1'b1; w_res = operand1_i[31:0] >> sh5; end
      ALU_SRAW:   begin use_w = 1'b1; w_res = $signed(operand1_i[31:0]) >>> sh5; end
      ALU_MUL:    alu_res = prod[XLEN-1:0];
      ALU_MULH:   alu_res = mul_hi - corr1 - corr2;
      ALU_MULHSU: alu_res = mul_hi - corr1;
      ALU_MULHU:  alu_res = mul_hi;
      ALU_MULW:   begin use_w = 1'b1; w_res = prod[31:0]; end
      default:    alu_res = '0;
    endcase
    if (use_w)
      alu_res = {{(XLEN-32){w_res[31]}}, w_res};
    if (load_i || store_i)
      alu_res = operand1_i + operand2_i;
  end

  logic            is_div, div_w, div_signed, div_rem;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_neg;
  logic            neg_a, neg_b, div_zero, div_ovf;

  always_comb begin
    is_div     = (aluop_i >= ALU_DIV) && (aluop_i <= ALU_REMUW) && !(load_i || store_i);
    div_w      = (aluop_i >= ALU_DIVW);
    div_signed = (aluop_i == ALU_DIV) || (aluop_i == ALU_REM) ||
                 (aluop_i == ALU_DIVW) || (aluop_i == ALU_REMW);
    div_rem    = (aluop_i == ALU_REM) || (aluop_i == ALU_REMU) ||
                 (aluop_i == ALU_REMW) || (aluop_i == ALU_REMUW);
    ext_a      = operand1_i;
    ext_b      = operand2_i;
    min_neg    = {1'b1, {(XLEN-1){1'b0}}};
    if (div_w) begin
      ext_a   = {{(XLEN-32){div_signed & operand1_i[31]}}, operand1_i[31:0]};
      ext_b   = {{(XLEN-32){div_signed & operand2_i[31]}}, operand2_i[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end
    neg_a    = div_signed & ext_a[XLEN-1];
    neg_b    = div_signed & ext_b[XLEN-1];
    mag_a    = neg_a ? -ext_a : ext_a;
    mag_b    = neg_b ? -ext_b : ext_b;
    div_zero = (ext_b == '0);
    div_ovf  = div_signed && (ext_a == min_neg) && (&ext_b);
  end

  logic [XLEN-1:0] quo_nxt, rem_nxt;
`ifdef DIV_RADIX4_EN
  logic [XLEN+1:0] x4, b1, b2, b3;
  // Compare the shifted partial remainder against 1x, 2x and 3x the divisor in parallel.
  always_comb begin
    x4      = {rem_q, quo_q[XLEN-1 -: 2]};
    b1      = {2'b00, div_b_q};
    b2      = {1'b0, div_b_q, 1'b0};
    b3      = b1 + b2;
    quo_nxt = {quo_q[XLEN-3:0], 2'b00};
    rem_nxt = x4[XLEN-1:0];
    if (x4 >= b3) begin
      rem_nxt      = XLEN'(x4 - b3);
      quo_nxt[1:0] = 2'b11;
    end else if (x4 >= b2) begin
      rem_nxt      = XLEN'(x4 - b2);
      quo_nxt[1:0] = 2'b10;
    end else if (x4 >= b1) begin
      rem_nxt      = XLEN'(x4 - b1);
      quo_nxt[1:0] = 2'b01;
    end
  end
`else
  logic [XLEN:0] x2;
  always_comb begin
    x2      = {rem_q, quo_q[XLEN-1]};
    quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    rem_nxt = x2[XLEN-1:0];
    if (x2 >= {1'b0, div_b_q}) begin
      rem_nxt    = XLEN'(x2 - {1'b0, div_b_q});
      quo_nxt[0] = 1'b1;
    end
  end
`endif

  logic [XLEN-1:0] q_fix, r_fix, sel_fix, fin_res;
  always_comb begin
    q_fix   = q_neg_q ? -quo_q : quo_q;
    r_fix   = r_neg_q ? -rem_q : rem_q;
    sel_fix = rem_sel_q ? r_fix : q_fix;
    fin_res = w_q ? {{(XLEN-32){sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end

  // Special divides preload the final quotient/remainder so FIN only has to pick and extend.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_b_q   <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      w_q       <= 1'b0;
      rf_wen_q  <= 1'b0;
      rd_q      <= '0;
      funct3_q  <= '0;
      valid_o   <= 1'b0;
      result_o  <= '0;
      rf_wen_o  <= 1'b0;
      rd_o      <= '0;
      load_o    <= 1'b0;
      store_o   <= 1'b0;
      funct3_o  <= '0;
      sdata_o   <= '0;
    end else begin
      valid_o  <= 1'b0;
      rf_wen_o <= 1'b0;
      load_o   <= 1'b0;
      store_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && !flush_i) begin
            if (is_div) begin
              rf_wen_q  <= rf_wen_i;
              rd_q      <= rd_i;
              funct3_q  <= funct3_i;
              rem_sel_q <= div_rem;
              w_q       <= div_w;
              div_b_q   <= mag_b;
              if (div_zero) begin
                quo_q   <= '1;
                rem_q   <= ext_a;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
                state   <= FIN;
              end else if (div_ovf) begin
                quo_q   <= ext_a;
                rem_q   <= '0;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
                state   <= FIN;
              end else begin
                quo_q   <= div_w ? {mag_a[31:0], 32'b0} : mag_a;
                rem_q   <= '0;
                q_neg_q <= neg_a ^ neg_b;
                r_neg_q <= neg_a;
                cnt     <= div_w ? 7'(ITER / 2) : 7'(ITER);
                state   <= DIV;
              end
            end else begin
              valid_o  <= 1'b1;
              result_o <= alu_res;
              rf_wen_o <= rf_wen_i;
              rd_o     <= rd_i;
              load_o   <= load_i;
              store_o  <= store_i;
              funct3_o <= funct3_i;
              sdata_o  <= sdata_i;
            end
          end
        end
        DIV: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt - 7'd1;
            if (cnt == 7'd1)
              state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          if (!flush_i) begin
            valid_o  <= 1'b1;
            result_o <= fin_res;
            rf_wen_o <= rf_wen_q;
            rd_o     <= rd_q;
            funct3_o <= funct3_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed pipeline/divider scenarios plus a randomized mix against a reference model.
`timescale 1ns/1ps
module tb_ex_stage;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_ADDW  = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd15;
  localparam logic [4:0] ALU_MULH  = 5'd16;
  localparam logic [4:0] ALU_MULHU = 5'd18;
  localparam logic [4:0] ALU_DIV   = 5'd20;
  localparam logic [4:0] ALU_DIVU  = 5'd21;
  localparam logic [4:0] ALU_REM   = 5'd22;
  localparam logic [4:0] ALU_REMU  = 5'd23;
  localparam logic [4:0] ALU_DIVW  = 5'd24;
  localparam logic [4:0] ALU_REMW  = 5'd26;
  localparam logic [4:0] ALU_REMUW = 5'd27;

`ifdef DIV_RADIX4_EN
  localparam int N_ITER = 32;
`else
  localparam int N_ITER = 64;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic [63:0] operand1_i = '0;
  logic [63:0] operand2_i = '0;
  logic [4:0]  aluop_i = '0;
  logic        rf_wen_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        load_i = 1'b0;
  logic        store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [63:0] sdata_i = '0;
  logic        valid_o;
  logic [63:0] result_o;
  logic        rf_wen_o;
  logic [4:0]  rd_o;
  logic        load_o;
  logic        store_o;
  logic [2:0]  funct3_o;
  logic [63:0] sdata_o;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        ld;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i), .aluop_i(aluop_i),
    .rf_wen_i(rf_wen_i), .rd_i(rd_i), .load_i(load_i), .store_i(store_i),
    .funct3_i(funct3_i), .sdata_i(sdata_i), .valid_o(valid_o), .result_o(result_o),
    .rf_wen_o(rf_wen_o), .rd_o(rd_o), .load_o(load_o), .store_o(store_o),
    .funct3_o(funct3_o), .sdata_o(sdata_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] refResult(input logic [4:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic ld);
    logic signed [63:0]  sa, sbv;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         a32, b32;
    logic [127:0]        p;
    logic                ovf64, ovf32;
    sa = a; sbv = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    if (ld) return a + b;
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLTU:  return {63'b0, a < b};
      ALU_SRA:   return sa >>> b[5:0];
      ALU_ADDW:  return sext32(a32 + b32);
      ALU_MUL:   return a * b;
      ALU_MULH:  begin
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return p[127:64];
      end
      ALU_MULHU: begin
        p = {64'b0, a} * {64'b0, b};
        return p[127:64];
      end
      ALU_DIV:   return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf64 ? a : 64'(sa / sbv);
      ALU_DIVU:  return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      ALU_REM:   return (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sbv);
      ALU_REMU:  return (b == 0) ? a : a % b;
      ALU_DIVW:  return (b32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf32 ? sext32(a32) : sext32(32'(sa32 / sb32));
      ALU_REMW:  return (b32 == 0) ? sext32(a32) : ovf32 ? 64'd0 : sext32(32'(sa32 % sb32));
      ALU_REMUW: return (b32 == 0) ? sext32(a32) : sext32(a32 % b32);
      default:   return 64'd0;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic ld);
    bit isW, isSigned, special;
    if (ld || op < ALU_DIV) return 1;
    isW = (op >= ALU_DIVW);
    isSigned = (op == ALU_DIV) || (op == ALU_REM) || (op == ALU_DIVW) || (op == ALU_REMW);
    if (isW)
      special = (b[31:0] == 0) || (isSigned && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else
      special = (b == 0) || (isSigned && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (special) return 2;
    return isW ? N_ITER / 2 + 2 : N_ITER + 2;
  endfunction

  task automatic applyStimulus(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input logic ld, input bit track,
                               input logic [63:0] expRes, input int lat);
    int   waitCycles = 0;
    exp_t e;
    @(negedge clk);
    while (!ready_o && waitCycles < 300) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!ready_o) checkOutput("ready_timeout", {63'b0, ready_o}, 64'd1);
    valid_i = 1'b1; aluop_i = op; operand1_i = a; operand2_i = b; rd_i = rd;
    rf_wen_i = 1'b1; load_i = ld; store_i = 1'b0; funct3_i = 3'd3; sdata_i = ~a;
    if (track) begin
      e.res = expRes; e.rd = rd; e.ld = ld; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // Output side of the scoreboard: every valid_o pulse must match the oldest outstanding entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result_o, e.res);
        checkOutput("rd", {59'b0, rd_o}, {59'b0, e.rd});
        checkOutput("rf_wen", {63'b0, rf_wen_o}, 64'd1);
        checkOutput("load", {63'b0, load_o}, {63'b0, e.ld});
        checkOutput("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  logic [4:0] opList [15] = '{ALU_ADD, ALU_SUB, ALU_SLTU, ALU_SRA, ALU_ADDW, ALU_MUL, ALU_MULH,
                              ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW,
                              ALU_REMW, ALU_REMUW};

  initial begin
    int lowCycles;
    int drain;
    logic [4:0]  op;
    logic [63:0] a, b;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("reset_valid", {63'b0, valid_o}, 64'd0);
    checkOutput("reset_result", result_o, 64'd0);

    applyStimulus(ALU_ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 5'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    applyStimulus(ALU_SLTU, 64'd1, 64'd2, 5'd2, 1'b0, 1'b1, 64'd1, 1);
    @(negedge clk);
    checkOutput("b2b_ready", {63'b0, ready_o}, 64'd1);

    applyStimulus(ALU_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd3, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, N_ITER + 2);
    lowCycles = 0;
    @(negedge clk);
    while (!ready_o && lowCycles < 300) begin
      lowCycles++;
      @(negedge clk);
    end
    checkOutput("div_ready_low", 64'(lowCycles), 64'(N_ITER + 1));

    applyStimulus(ALU_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd4, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, N_ITER + 2);
    applyStimulus(ALU_DIVU, 64'd7, 64'd0, 5'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    applyStimulus(ALU_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 1'b0, 1'b1, 64'd0, 2);
    applyStimulus(ALU_DIVW, 64'h0000_0000_FFFF_FFF6, 64'd2, 5'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, N_ITER / 2 + 2);

    applyStimulus(ALU_DIV, 64'd100, 64'd7, 5'd8, 1'b0, 1'b0, 64'd0, 0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("flush_valid", {63'b0, valid_o}, 64'd0);
    applyStimulus(ALU_ADD, 64'd1, 64'd1, 5'd9, 1'b0, 1'b1, 64'd2, 1);

    applyStimulus(ALU_DIV, 64'd1000, 64'd9, 5'd10, 1'b0, 1'b0, 64'd0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstdiv_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("rstdiv_valid", {63'b0, valid_o}, 64'd0);
    checkOutput("rstdiv_result", result_o, 64'd0);
    checkOutput("rstdiv_rd", {59'b0, rd_o}, 64'd0);
    checkOutput("rstdiv_sdata", sdata_o, 64'd0);
    checkOutput("rstdiv_funct3", {61'b0, funct3_o}, 64'd0);
    applyStimulus(ALU_MULH, 64'h8000_0000_0000_0000, 64'd2, 5'd11, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    applyStimulus(ALU_ADD, 64'h1000, 64'h10, 5'd12, 1'b1, 1'b1, 64'h1010, 1);

    for (int i = 0; i < 24; i++) begin
      op = opList[$urandom_range(0, 14)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (op >= ALU_DIV && $urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 5));
      applyStimulus(op, a, b, 5'(i), 1'b0, 1'b1, refResult(op, a, b, 1'b0), latency(op, a, b, 1'b0));
    end

    drain = 0;
    while (sb.size() > 0 && drain < 300) begin
      @(negedge clk);
      drain++;
    end
    checkOutput("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
